// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream registered-read FIFO and sends
// them as 8-bit UART frames (start, 8 data LSB first, optional parity, stop).
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   enable      permits starting a new frame (never aborts one in progress)
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle pop strobe (combinational, IDLE only)
//   tx          registered serial line, idle high
//   busy        registered, high whenever the FSM is not IDLE
//   frame_done  registered one-cycle pulse on the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BAUD_W = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  // frame_done is registered, so it is armed one cycle before the last stop cycle
  localparam logic [BAUD_W-1:0] DONE_ARM  = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud, baud_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [7:0]        shreg, shreg_n;
  logic              par_bit, par_bit_n;
  logic              tx_n, busy_n, frame_done_n;
  logic              bit_end;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    fifo_rd_en = 1'b0;
    bit_end    = (baud == BAUD_LAST);
    baud_n     = bit_end ? '0 : baud + BAUD_W'(1);

    case (state)
      IDLE: begin
        baud_n    = '0;
        bit_idx_n = '0;
        if (enable && !fifo_empty) begin
          // gated by rst_n so no pop can escape while reset is held
          fifo_rd_en = rst_n;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        baud_n    = '0;
        shreg_n   = fifo_data;
        par_bit_n = (^fifo_data) ^ (PARITY_ODD != 0);
        state_n   = START;
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_n   = {1'b0, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (bit_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // tx is registered, so it is decoded from the upcoming state
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_bit_n;
      default: tx_n = 1'b1;
    endcase

    busy_n       = (state_n != IDLE);
    frame_done_n = (state == STOP) && (baud == DONE_ARM);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three DUTs (no parity, even parity, odd parity) at
// CLKS_PER_BIT=4, each fed by a small registered-read FIFO model. Bytes are
// pushed to a scoreboard when loaded into a FIFO; the frame receiver pops
// them and checks every cycle of tx, busy and frame_done against a bit model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] enable;
  logic [2:0] fifo_empty;
  logic [2:0] rd_en;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] fdata [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_data(fdata[0]), .fifo_rd_en(rd_en[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(done[0]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_data(fdata[1]), .fifo_rd_en(rd_en[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(done[1]));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst_n(rst_n[2]), .enable(enable[2]), .fifo_empty(fifo_empty[2]),
    .fifo_data(fdata[2]), .fifo_rd_en(rd_en[2]), .tx(tx[2]), .busy(busy[2]),
    .frame_done(done[2]));

  // FIFO model: 16-entry memories, registered read data, random data otherwise
  logic [7:0] fmem [3][16];
  int         wp [3]      = '{0, 0, 0};
  int         rp [3]      = '{0, 0, 0};
  int         pops [3]    = '{0, 0, 0};
  int         pop_cyc [3] = '{0, 0, 0};
  int         bad_pops    = 0;
  int         cyc         = 0;
  logic [2:0] rd_prev     = 3'b000;

  assign fifo_empty[0] = (wp[0] == rp[0]);
  assign fifo_empty[1] = (wp[1] == rp[1]);
  assign fifo_empty[2] = (wp[2] == rp[2]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i]) begin
        if (fifo_empty[i] || rd_prev[i] || !rst_n[i]) bad_pops <= bad_pops + 1;
        fdata[i]   <= fmem[i][rp[i] % 16];
        rp[i]      <= rp[i] + 1;
        pops[i]    <= pops[i] + 1;
        pop_cyc[i] <= cyc;
      end else begin
        fdata[i] <= 8'($urandom);
      end
    end
    rd_prev <= rd_en;
  end

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] exp_q2 [$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input int i, input logic [7:0] b);
    fmem[i][wp[i] % 16] = b;
    wp[i] = wp[i] + 1;
    case (i)
      0:       exp_q0.push_back(b);
      1:       exp_q1.push_back(b);
      default: exp_q2.push_back(b);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    case (i)
      0:       if (exp_q0.size() > 0) begin b = exp_q0.pop_front(); ok = 1'b1; end
      1:       if (exp_q1.size() > 0) begin b = exp_q1.pop_front(); ok = 1'b1; end
      default: if (exp_q2.size() > 0) begin b = exp_q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Returns the cycle index of the first start-bit cycle; bounded wait
  task automatic wait_start(input int i, output int s, output bit ok);
    ok = 1'b0;
    s  = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx[i] == 1'b0) begin
        ok = 1'b1;
        s  = cyc;
        break;
      end
    end
    if (!ok) check($sformatf("start_timeout d%0d", i), 0, 1);
  endtask

  // Receive one frame, comparing every cycle with the expected bit pattern
  task automatic rx_frame(input int i, input int npar, input bit odd,
                          input int drop_bit, output int s);
    logic [7:0] b;
    bit         ok;
    logic       eb;
    int         nbits;
    pop_exp(i, b, ok);
    check($sformatf("sb_has_byte d%0d", i), int'(ok), 1);
    wait_start(i, s, ok);
    if (!ok) return;
    check($sformatf("latency d%0d", i), s - pop_cyc[i], 2);
    nbits = 10 + npar;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < CPB; c++) begin
        if (k != 0 || c != 0) @(negedge clk);
        if (k == 0)                    eb = 1'b0;
        else if (k <= 8)               eb = b[k-1];
        else if (npar != 0 && k == 9)  eb = (^b) ^ odd;
        else                           eb = 1'b1;
        check($sformatf("tx d%0d byte%02h bit%0d c%0d", i, b, k, c), int'(tx[i]), int'(eb));
        check($sformatf("busy d%0d bit%0d c%0d", i, k, c), int'(busy[i]), 1);
        check($sformatf("done d%0d bit%0d c%0d", i, k, c), int'(done[i]),
              int'(k == nbits - 1 && c == CPB - 1));
        if (k == drop_bit && c == 0) enable[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         s, s2, p0;
    bit         ok;
    logic [7:0] junk;

    // Reset held with a byte queued and enable high: no pop, idle outputs
    rst_n  = 3'b000;
    enable = 3'b001;
    push_byte(0, 8'hA5);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_tx d%0d", i), int'(tx[i]), 1);
      check($sformatf("rst_busy d%0d", i), int'(busy[i]), 0);
      check($sformatf("rst_done d%0d", i), int'(done[i]), 0);
      check($sformatf("rst_rd_en d%0d", i), int'(rd_en[i]), 0);
    end
    rst_n = 3'b111;

    // 0xA5, no parity: latency 2, 40-cycle frame, done on last stop cycle
    rx_frame(0, 0, 1'b0, -1, s);
    @(negedge clk);
    check("idle_after_a5_busy", int'(busy[0]), 0);
    check("idle_after_a5_done", int'(done[0]), 0);

    // Empty FIFO with enable: nothing happens for 100 cycles
    p0 = pops[0];
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n % 20 == 0) begin
        check($sformatf("empty_tx n%0d", n), int'(tx[0]), 1);
        check($sformatf("empty_busy n%0d", n), int'(busy[0]), 0);
      end
    end
    check("empty_no_pop", pops[0] - p0, 0);

    // Enable dropped in data bit 3 of 0x3C: frame completes, 0x55 waits
    push_byte(0, 8'h3C);
    push_byte(0, 8'h55);
    rx_frame(0, 0, 1'b0, 4, s);
    repeat (20) @(negedge clk);
    check("hold_pop_count", pops[0] - p0, 1);
    check("hold_busy", int'(busy[0]), 0);
    check("hold_tx", int'(tx[0]), 1);
    enable[0] = 1'b1;
    rx_frame(0, 0, 1'b0, -1, s);

    // Even parity, back to back: 0xA5 then 0x07, 46-cycle start spacing
    push_byte(1, 8'hA5);
    push_byte(1, 8'h07);
    enable[1] = 1'b1;
    rx_frame(1, 1, 1'b0, -1, s);
    rx_frame(1, 1, 1'b0, -1, s2);
    check("b2b_spacing", s2 - s, 46);
    enable[1] = 1'b0;

    // Odd parity on 0x00
    push_byte(2, 8'h00);
    enable[2] = 1'b1;
    rx_frame(2, 1, 1'b1, -1, s);
    enable[2] = 1'b0;

    // Reset during data bit 5 of 0xF0; 0x81 then sent as a clean frame
    enable[0] = 1'b0;
    repeat (20) @(negedge clk);
    push_byte(0, 8'hF0);
    push_byte(0, 8'h81);
    enable[0] = 1'b1;
    pop_exp(0, junk, ok);
    wait_start(0, s, ok);
    repeat (24) @(negedge clk);
    check("pre_rst_in_bit5", int'(tx[0]), int'(junk[5]));
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("midrst_tx", int'(tx[0]), 1);
    check("midrst_busy", int'(busy[0]), 0);
    check("midrst_done", int'(done[0]), 0);
    check("midrst_rd_en", int'(rd_en[0]), 0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    rx_frame(0, 0, 1'b0, -1, s);

    check("bad_pops", bad_pops, 0);
    check("total_pops_d0", pops[0], 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
